// File: rtl/bsg_cache_dma_responder_pkg.sv
// Shared declarations for the DMA responder.
//   - FSM state encodings (plain localparams for legacy tool compatibility)
//   - max1(): clamps derived widths so degenerate parameters never give zero-width vectors
package bsg_cache_dma_responder_pkg;

    localparam int unsigned StateWidth = 2;

    localparam logic [StateWidth-1:0] StIdle  = 2'd0;
    localparam logic [StateWidth-1:0] StDelay = 2'd1;
    localparam logic [StateWidth-1:0] StRead  = 2'd2;
    localparam logic [StateWidth-1:0] StWrite = 2'd3;

    function automatic int unsigned max1(input int unsigned x);
        return (x == 0) ? 1 : x;
    endfunction

endpackage

// File: rtl/bsg_cache_dma_responder_mem.sv
// Backing store for the DMA responder: one write port, one asynchronous read port.
// Contents are deliberately not reset.
//   clk_i     : clock
//   w_v_i     : write enable, sampled at the rising edge
//   w_addr_i  : write word address
//   w_data_i  : write data
//   r_addr_i  : read word address
//   r_data_o  : read data (combinational from r_addr_i)
module bsg_cache_dma_responder_mem
    import bsg_cache_dma_responder_pkg::*;
#(
    parameter int unsigned width_p = 32,
    parameter int unsigned els_p   = 256,
    localparam int unsigned AddrW  = max1($clog2(els_p))
) (
    input  logic               clk_i,
    input  logic               w_v_i,
    input  logic [AddrW-1:0]   w_addr_i,
    input  logic [width_p-1:0] w_data_i,
    input  logic [AddrW-1:0]   r_addr_i,
    output logic [width_p-1:0] r_data_o
);

    logic [width_p-1:0] r_mem [els_p];

    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            r_mem[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = r_mem[r_addr_i];

endmodule

// File: rtl/bsg_cache_dma_responder.sv
// Memory-backed responder for the cache DMA interface. Accepts one packet at a time; a read
// packet streams a whole block out on dma_data_o, a write packet absorbs a whole block from
// dma_data_i. Addresses are block-aligned and wrap modulo the memory depth.
//   clk_i, reset_i                          : clock, synchronous active-high reset
//   dma_pkt_i / dma_pkt_v_i / dma_pkt_yumi_o : {write_not_read, addr} packet handshake
//   dma_data_o / dma_data_v_o / dma_data_ready_i : fill (read) data to the cache
//   dma_data_i / dma_data_v_i / dma_data_yumi_o  : evict (write) data from the cache
module bsg_cache_dma_responder
    import bsg_cache_dma_responder_pkg::*;
#(
    parameter int unsigned data_width_p          = 32,
    parameter int unsigned addr_width_p          = 32,
    parameter int unsigned block_size_in_words_p = 8,
    parameter int unsigned els_p                 = 1024,
    parameter int unsigned read_delay_p          = 0
) (
    input  logic                    clk_i,
    input  logic                    reset_i,

    input  logic [addr_width_p:0]   dma_pkt_i,
    input  logic                    dma_pkt_v_i,
    output logic                    dma_pkt_yumi_o,

    output logic [data_width_p-1:0] dma_data_o,
    output logic                    dma_data_v_o,
    input  logic                    dma_data_ready_i,

    input  logic [data_width_p-1:0] dma_data_i,
    input  logic                    dma_data_v_i,
    output logic                    dma_data_yumi_o
);

    localparam int unsigned LgBytes = $clog2(data_width_p / 8);
    localparam int unsigned LgEls   = max1($clog2(els_p));
    localparam int unsigned CntW    = max1($clog2(block_size_in_words_p));
    localparam int unsigned DlyW    = max1($clog2(read_delay_p + 1));

    typedef struct packed {
        logic                    write_not_read;
        logic [addr_width_p-1:0] addr;
    } dma_pkt_s;

    dma_pkt_s w_pkt;
    assign w_pkt = dma_pkt_i;

    logic [StateWidth-1:0] r_state, w_state_next;
    logic [LgEls-1:0]      r_base,  w_base_next;
    logic [CntW-1:0]       r_count, w_count_next;
    logic [DlyW-1:0]       r_delay, w_delay_next;

    // Byte address -> word index, low block bits cleared; the cast takes it modulo els_p.
    logic [LgEls-1:0] w_pkt_base;
    assign w_pkt_base = LgEls'(w_pkt.addr >> LgBytes) & ~LgEls'(block_size_in_words_p - 1);

    logic w_last;
    assign w_last = (r_count == CntW'(block_size_in_words_p - 1));

    // Outputs are gated by reset so they are already quiet in the reset cycle itself.
    logic w_pkt_yumi, w_data_v, w_data_yumi, w_read_xfer;
    assign w_pkt_yumi  = ~reset_i & (r_state == StIdle) & dma_pkt_v_i;
    assign w_data_v    = ~reset_i & (r_state == StRead);
    assign w_data_yumi = ~reset_i & (r_state == StWrite) & dma_data_v_i;
    assign w_read_xfer = w_data_v & dma_data_ready_i;

    always_comb begin
        w_state_next = r_state;
        w_base_next  = r_base;
        w_count_next = r_count;
        w_delay_next = r_delay;
        case (r_state)
            StIdle: begin
                if (w_pkt_yumi) begin
                    w_base_next  = w_pkt_base;
                    w_count_next = '0;
                    w_delay_next = '0;
                    if (w_pkt.write_not_read) begin
                        w_state_next = StWrite;
                    end else if (read_delay_p > 0) begin
                        w_state_next = StDelay;
                    end else begin
                        w_state_next = StRead;
                    end
                end
            end
            StDelay: begin
                if (r_delay == DlyW'(read_delay_p - 1)) begin
                    w_state_next = StRead;
                end else begin
                    w_delay_next = r_delay + 1'b1;
                end
            end
            StRead: begin
                if (w_read_xfer) begin
                    w_count_next = r_count + 1'b1;
                    if (w_last) w_state_next = StIdle;
                end
            end
            StWrite: begin
                if (w_data_yumi) begin
                    w_count_next = r_count + 1'b1;
                    if (w_last) w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= StIdle;
            r_base  <= '0;
            r_count <= '0;
            r_delay <= '0;
        end else begin
            r_state <= w_state_next;
            r_base  <= w_base_next;
            r_count <= w_count_next;
            r_delay <= w_delay_next;
        end
    end

    logic [LgEls-1:0] w_mem_addr;
    assign w_mem_addr = r_base + LgEls'(r_count);

    bsg_cache_dma_responder_mem #(
        .width_p (data_width_p),
        .els_p   (els_p)
    ) u_bsg_mem_1r1w (
        .clk_i    (clk_i),
        .w_v_i    (w_data_yumi),
        .w_addr_i (w_mem_addr),
        .w_data_i (dma_data_i),
        .r_addr_i (w_mem_addr),
        .r_data_o (dma_data_o)
    );

    assign dma_pkt_yumi_o  = w_pkt_yumi;
    assign dma_data_v_o    = w_data_v;
    assign dma_data_yumi_o = w_data_yumi;

endmodule
